// File: rtl/cordic_vector_pkg.sv
// Shared constants, Q-format widths and FSM encoding for the vectoring CORDIC.
package cordic_vector_pkg;
  localparam int ITER  = 12;
  localparam int IN_W  = 8;
  localparam int DP_W  = 14;
  localparam int FRAC  = 10;
  localparam int CNT_W = 4;
  localparam int LUT_W = 12;

  localparam logic signed [DP_W-1:0] PI_Q10 = 14'sd3217;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ITER,
    ST_COMP,
    ST_DONE
  } state_t;
endpackage

// File: rtl/cordic_vector_lut.sv
// Arctangent table: atan(2^-idx) in unsigned Q2.10, idx = 0..11.
module cordic_vector_lut
  import cordic_vector_pkg::*;
(
  input  logic [CNT_W-1:0] idx,
  output logic [LUT_W-1:0] atan
);
  always_comb begin
    atan = '0;
    case (idx)
      4'd0:  atan = 12'd804;
      4'd1:  atan = 12'd475;
      4'd2:  atan = 12'd251;
      4'd3:  atan = 12'd127;
      4'd4:  atan = 12'd64;
      4'd5:  atan = 12'd32;
      4'd6:  atan = 12'd16;
      4'd7:  atan = 12'd8;
      4'd8:  atan = 12'd4;
      4'd9:  atan = 12'd2;
      4'd10: atan = 12'd1;
      default: atan = '0;
    endcase
  end
endmodule

// File: rtl/cordic_vector.sv
// Vectoring-mode CORDIC: (x, y) -> atan2 angle (Q2.6) and magnitude.
// CORDIC_VEC_GAIN_COMP_EN adds a COMP state that removes the CORDIC gain (mag in Q1.7).
module cordic_vector
  import cordic_vector_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] x_in,
  input  logic [IN_W-1:0] y_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      angle,
  output logic [7:0]      mag,
  output logic            out_sat
);
  state_t state, state_nx;

  logic [CNT_W-1:0]       count;
  logic signed [DP_W-1:0] x, y, z;
  logic                   zero_vec;
  logic [LUT_W-1:0]       atan;
  logic signed [DP_W-1:0] atan_s, x_sh, y_sh;
  logic signed [DP_W-1:0] x_ext, y_ext, x_ld, y_ld, z_ld;
  logic signed [DP_W-1:0] x_fin;
  logic signed [DP_W:0]   z_rnd, z_q, m_rnd, m_q;
  logic [7:0]             angle_nx, mag_nx;
  logic                   sat_nx, last, fmt_en;

  cordic_vector_lut lut (.idx(count), .atan(atan));

  assign atan_s = {{(DP_W-LUT_W){1'b0}}, atan};
  assign x_sh   = x >>> count;
  assign y_sh   = y >>> count;

  // count==ITER is a settle cycle with no rotation, so formatting sees final x/z
  assign last   = (count == CNT_W'(ITER));

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign fmt_en    = (state_nx == ST_DONE) && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid) state_nx = ST_ITER;
      ST_ITER: if (last) begin
`ifdef CORDIC_VEC_GAIN_COMP_EN
        state_nx = ST_COMP;
`else
        state_nx = ST_DONE;
`endif
      end
      ST_COMP: state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Left half-plane inputs are folded by negation; z starts at +/-pi to compensate.
  always_comb begin
    x_ext = {{(DP_W-IN_W-3){x_in[IN_W-1]}}, x_in, 3'b000};
    y_ext = {{(DP_W-IN_W-3){y_in[IN_W-1]}}, y_in, 3'b000};
    x_ld  = x_ext;
    y_ld  = y_ext;
    z_ld  = '0;
    if (x_in[IN_W-1]) begin
      x_ld = -x_ext;
      y_ld = -y_ext;
      z_ld = y_in[IN_W-1] ? -PI_Q10 : PI_Q10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      zero_vec <= 1'b0;
      angle    <= '0;
      mag      <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        count    <= '0;
        x        <= x_ld;
        y        <= y_ld;
        z        <= z_ld;
        zero_vec <= (x_in == '0) && (y_in == '0);
      end else if (state == ST_ITER && !last) begin
        if (!y[DP_W-1]) begin
          x <= x + y_sh;
          y <= y - x_sh;
          z <= z + atan_s;
        end else begin
          x <= x - y_sh;
          y <= y + x_sh;
          z <= z - atan_s;
        end
        count <= count + CNT_W'(1);
      end
      if (fmt_en) begin
        angle   <= angle_nx;
        mag     <= mag_nx;
        out_sat <= sat_nx;
      end
    end
  end

  always_comb begin
    x_fin = x;
`ifdef CORDIC_VEC_GAIN_COMP_EN
    x_fin = (x >>> 1) + (x >>> 3) - (x >>> 6) - (x >>> 9);
    m_rnd = {x_fin[DP_W-1], x_fin} + (DP_W+1)'(4);
    m_q   = m_rnd >>> 3;
`else
    m_rnd = {x_fin[DP_W-1], x_fin} + (DP_W+1)'(8);
    m_q   = m_rnd >>> 4;
`endif
    z_rnd = {z[DP_W-1], z} + (DP_W+1)'(8);
    z_q   = z_rnd >>> 4;

    sat_nx   = 1'b0;
    angle_nx = z_q[7:0];
    if (z_q > 127) begin
      angle_nx = 8'h7F;
      sat_nx   = 1'b1;
    end else if (z_q < -128) begin
      angle_nx = 8'h80;
      sat_nx   = 1'b1;
    end

    mag_nx = m_q[7:0];
    if (m_q < 0)        mag_nx = 8'h00;
    else if (m_q > 255) mag_nx = 8'hFF;

    // The zero vector never leaves y>=0, so z would drift to sum(atan).
    if (zero_vec) begin
      angle_nx = '0;
      mag_nx   = '0;
      sat_nx   = 1'b0;
    end
  end
endmodule

// File: tb/tb_cordic_vector.sv
// Bench for cordic_vector: directed table, random vectors vs a real-arithmetic model,
// out_ready stall and mid-run reset sequences.
module tb_cordic_vector;
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int LAT  = 14;
  localparam bit COMP = 1'b1;
`else
  localparam int LAT  = 13;
  localparam bit COMP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [7:0] x_in, y_in, angle, mag;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_vector dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
    .angle(angle), .mag(mag), .out_sat(out_sat)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    int angle;
    int tol_a;
    int mag_c;
    int mag_r;
    int tol_m;
    int sat;
  } vec_t;

  task automatic chk(input string name, input int got, input int exp, input int tol);
    int d;
    d = got - exp;
    if (d < 0) d = -d;
    checks++;
    if (d > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", name, got, exp, tol);
    end
  endtask

  function automatic int rnd(input real v);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  // Ideal atan2 / magnitude in the output formats; es=-1 means too close to the clamp edge.
  function automatic void model(input logic [7:0] xv, input logic [7:0] yv,
                                output int ea, output int em, output int es);
    real xr, yr, a64, r;
    xr = $signed(xv);
    yr = $signed(yv);
    if (xv == 8'h00 && yv == 8'h00) begin
      ea = 0; em = 0; es = 0;
      return;
    end
    a64 = $atan2(yr, xr) * 64.0;
    ea  = rnd(a64);
    if (ea > 127)  ea = 127;
    if (ea < -128) ea = -128;
    if (a64 > 129.5 || a64 < -130.5)     es = 1;
    else if (a64 < 125.5 && a64 > -126.5) es = 0;
    else                                  es = -1;
    r  = $sqrt(xr * xr + yr * yr);
    em = COMP ? rnd(r) : rnd(r * 1.64676 / 2.0);
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 40);
  endtask

  // Full transaction with out_ready high; returns captured outputs and latency.
  task automatic run_vec(input logic [7:0] xv, input logic [7:0] yv,
                         output int a, output int m, output int s, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    x_in = xv; y_in = yv; in_valid = 1'b1; out_ready = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", int'(in_ready), 1, 0);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    a = $signed(angle);
    m = mag;
    s = out_sat;
    @(negedge clk);
    chk("out_valid_pulse", int'(out_valid), 0, 0);
    chk("idle_ready", int'(in_ready), 1, 0);
  endtask

  vec_t tbl[9];

  initial begin
    int a, m, s, lat, ea, em, es, a0, m0, s0, seen;
    logic [7:0] rx, ry;

    tbl[0] = '{8'h40, 8'h00,    0, 1,  64,  53, 1, 0};
    tbl[1] = '{8'h40, 8'h40,   50, 1,  90,  75, 1, 0};
    tbl[2] = '{8'h00, 8'h40,  100, 1,  64,  53, 1, 0};
    tbl[3] = '{8'h00, 8'hC0, -100, 1,  64,  53, 1, 0};
    tbl[4] = '{8'hC0, 8'h01,  127, 0,  64,  53, 1, 1};
    tbl[5] = '{8'hC0, 8'hFF, -128, 0,  64,  53, 1, 1};
    tbl[6] = '{8'h00, 8'h00,    0, 0,   0,   0, 0, 0};
    tbl[7] = '{8'h80, 8'h00,  127, 0, 128, 105, 1, 1};
    tbl[8] = '{8'h7F, 8'h80,  -51, 1, 180, 148, 2, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x_in = '0; y_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1, 0);
    chk("rst_out_valid", int'(out_valid), 0, 0);
    chk("rst_angle", int'(angle), 0, 0);
    chk("rst_mag", int'(mag), 0, 0);
    chk("rst_out_sat", int'(out_sat), 0, 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i].x, tbl[i].y, a, m, s, lat);
      chk($sformatf("dir%0d_angle", i), a, tbl[i].angle, tbl[i].tol_a);
      chk($sformatf("dir%0d_mag", i), m, COMP ? tbl[i].mag_c : tbl[i].mag_r, tbl[i].tol_m);
      chk($sformatf("dir%0d_sat", i), s, tbl[i].sat, 0);
      chk($sformatf("dir%0d_latency", i), lat, LAT, 0);
    end

    for (int i = 0; i < 40; i++) begin
      do begin
        rx = 8'($urandom_range(0, 255));
        ry = 8'($urandom_range(0, 255));
      end while ($signed(rx) * $signed(rx) + $signed(ry) * $signed(ry) < 1024);
      model(rx, ry, ea, em, es);
      run_vec(rx, ry, a, m, s, lat);
      chk($sformatf("rnd%0d_angle x=%02h y=%02h", i, rx, ry), a, ea, 2);
      chk($sformatf("rnd%0d_mag x=%02h y=%02h", i, rx, ry), m, em, 2);
      if (es >= 0) chk($sformatf("rnd%0d_sat", i), s, es, 0);
    end

    // Stall in DONE with a competing input pending.
    model(8'h30, 8'h10, ea, em, es);
    @(negedge clk);
    x_in = 8'h30; y_in = 8'h10; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk("hold_latency", lat, LAT, 0);
    a0 = $signed(angle); m0 = mag; s0 = out_sat;
    chk("hold_a_angle", a0, ea, 2);
    chk("hold_a_mag", m0, em, 2);
    x_in = 8'h10; y_in = 8'h50; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), int'(out_valid), 1, 0);
      chk($sformatf("hold%0d_in_ready", k), int'(in_ready), 0, 0);
      chk($sformatf("hold%0d_angle", k), $signed(angle), a0, 0);
      chk($sformatf("hold%0d_mag", k), int'(mag), m0, 0);
      chk($sformatf("hold%0d_sat", k), int'(out_sat), s0, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("hold_idle_ready", int'(in_ready), 1, 0);
    chk("hold_idle_valid", int'(out_valid), 0, 0);
    @(negedge clk);
    chk("hold_b_accepted", int'(in_ready), 0, 0);
    in_valid = 1'b0;
    model(8'h10, 8'h50, ea, em, es);
    wait_valid(lat);
    chk("hold_b_latency", lat, LAT, 0);
    chk("hold_b_angle", $signed(angle), ea, 2);
    chk("hold_b_mag", int'(mag), em, 2);
    @(negedge clk);

    // Reset in the middle of the iterations.
    x_in = 8'h50; y_in = 8'hD0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", int'(out_valid), 0, 0);
    chk("midrst_in_ready", int'(in_ready), 1, 0);
    chk("midrst_angle", int'(angle), 0, 0);
    chk("midrst_mag", int'(mag), 0, 0);
    chk("midrst_sat", int'(out_sat), 0, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_partial", seen, 0, 0);
    model(8'h50, 8'hD0, ea, em, es);
    run_vec(8'h50, 8'hD0, a, m, s, lat);
    chk("midrst_fresh_angle", a, ea, 2);
    chk("midrst_fresh_mag", m, em, 2);
    chk("midrst_fresh_latency", lat, LAT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
